ds_rr_arbiter: RTL

Round-robin arbiter that merges INPUTS DataStream sources into one DataStream output, typically placed in front of a ds_scfifo_buffer shared by several producers. Grants one source at a time and holds the grant for a burst of up to BURST words. The selected source's data path is combinational, with zero added latency once granted. Arbitration costs one idle cycle per grant.

---
 rtl/ds_arb_pkg.sv | 29 ++
 rtl/ds_rr_pick.sv | 17 +
 rtl/ds_rr_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/ds_arb_pkg.sv
// Shared types and helpers for DataStream arbiters.
// rr_first returns the first set request at or after 'start', wrapping at n.
package ds_arb_pkg;

    typedef enum logic {IDLE, GRANT} ds_arb_state_t;

    localparam int unsigned MAX_REQ = 32;

    function automatic int unsigned rr_first(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        n,
        input int unsigned        start
    );
        int unsigned idx;
        logic        found;
        rr_first = 0;
        found    = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            // start < n and i < n, so one subtraction is enough to wrap
            idx = start + i;
            if (idx >= n) idx = idx - n;
            if ((i < n) && !found && req[idx[4:0]]) begin
                rr_first = idx;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/ds_rr_pick.sv
// Combinational round-robin picker: first request at or above i_ptr, wrapping.
module ds_rr_pick
    import ds_arb_pkg::*;
#(
    parameter int unsigned INPUTS = 4,
    localparam int unsigned SW    = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0] i_req,
    input  logic [SW-1:0]     i_ptr,
    output logic [SW-1:0]     o_idx,
    output logic              o_any
);

    assign o_idx = SW'(rr_first(MAX_REQ'(i_req), INPUTS, 32'(i_ptr)));
    assign o_any = |i_req;

endmodule

// File: rtl/ds_rr_arbiter.sv
// Round-robin DataStream merger: one owner per grant, bursts of up to BURST words,
// one idle arbitration cycle between grants, combinational data/ready path.
module ds_rr_arbiter
    import ds_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned INPUTS = 4,
    parameter int unsigned BURST  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [INPUTS-1:0][WIDTH-1:0]  i_dat,
    input  logic [INPUTS-1:0]             i_val,
    output logic [INPUTS-1:0]             i_rdy,
    output logic [WIDTH-1:0]              o_dat,
    output logic                          o_val,
    input  logic                          o_rdy,
    output logic [INPUTS-1:0]             grant
);

    localparam int unsigned SW = $clog2(INPUTS);
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    ds_arb_state_t   r_state;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_ptr;
    logic [BW-1:0]   r_bcnt;

    logic [SW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_granted;
    logic              w_xfer;
    logic              w_release;
    logic [INPUTS-1:0] w_onehot;

    ds_rr_pick #(
        .INPUTS (INPUTS)
    ) u_pick (
        .i_req (i_val),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_granted = (r_state == GRANT);
    assign w_onehot  = {{(INPUTS-1){1'b0}}, 1'b1} << r_sel;

    assign o_dat = i_dat[r_sel];
    assign o_val = w_granted & i_val[r_sel];
    assign i_rdy = (w_granted & o_rdy) ? w_onehot : '0;
    assign grant = w_granted ? w_onehot : '0;

    assign w_xfer    = o_val & o_rdy;
    // A valid gap from the owner ends its burst early.
    assign w_release = w_granted &
                       (!i_val[r_sel] | (w_xfer & (r_bcnt == BW'(BURST - 1))));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_bcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_sel   <= w_pick_idx;
                        r_bcnt  <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr   <= (r_sel == SW'(INPUTS - 1)) ? '0 : r_sel + 1'b1;
                        r_bcnt  <= '0;
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
